// File: rtl/hack_boot_loader_pkg.sv
// Shared definitions for the Hack boot loader: word/address widths and FSM state encoding.
package hack_boot_loader_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 15;
    localparam int HOLD_W = 8;

    typedef enum logic [2:0] {
        ST_LEN     = 3'd0,
        ST_DATA    = 3'd1,
        ST_CHECK   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4,
        ST_ERROR   = 3'd5
    } state_e;

    // States in which the loader is consuming the stream.
    function automatic logic is_loading(input state_e s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/boot_checksum.sv
// 16-bit modular accumulator over the payload words; clear wins over add.
module boot_checksum
    import hack_boot_loader_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic              add_en,
    input  logic [WORD_W-1:0] add_word,
    output logic [WORD_W-1:0] sum
);

    logic [WORD_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clear) begin
            sum_d = '0;
        end else if (add_en) begin
            sum_d = sum_q + add_word;
        end
    end

    always_ff @(posedge clock) begin
        sum_q <= sum_d;
    end

    assign sum = sum_q;

endmodule

// File: rtl/hack_boot_loader.sv
// Boot sequencer: streams a length-prefixed, checksummed image into ROM32K, then
// releases CPU reset after a fixed hold. Every output is a flop.
module hack_boot_loader
    import hack_boot_loader_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int MAX_LEN     = 32767
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] rom_address,
    output logic [WORD_W-1:0] rom_in,
    output logic              rom_load,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [WORD_W-1:0] MAX_LEN_W = WORD_W'(MAX_LEN);
    localparam logic [HOLD_W-1:0] HOLD_W_V  = HOLD_W'(HOLD_CYCLES);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [ADDR_W-1:0] rom_address_q, rom_address_d;
    logic [WORD_W-1:0] rom_in_q, rom_in_d;
    logic              rom_load_q, rom_load_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              sum_clr;
    logic              sum_add;
    logic [WORD_W-1:0] sum;

    assign accept = in_valid & in_ready_q;

    boot_checksum u_checksum (
        .clock    (clock),
        .clear    (reset | sum_clr),
        .add_en   (sum_add),
        .add_word (in_data),
        .sum      (sum)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        hold_d        = hold_q;
        rom_address_d = rom_address_q;
        rom_in_d      = rom_in_q;
        rom_load_d    = 1'b0;
        cpu_reset_d   = cpu_reset_q;
        done_d        = done_q;
        error_d       = error_q;
        sum_clr       = 1'b0;
        sum_add       = 1'b0;

        case (state_q)
            ST_LEN: begin
                if (accept) begin
                    if (in_data == '0 || in_data > MAX_LEN_W) begin
                        state_d = ST_ERROR;
                    end else begin
                        len_d   = in_data[ADDR_W-1:0];
                        cnt_d   = '0;
                        sum_clr = 1'b1;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    rom_address_d = cnt_q;
                    rom_in_d      = in_data;
                    rom_load_d    = 1'b1;
                    sum_add       = 1'b1;
                    cnt_d         = cnt_q + 1'b1;
                    if (cnt_q == len_q - 1'b1) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    hold_d  = '0;
                    state_d = (in_data == sum) ? ST_RELEASE : ST_ERROR;
                end
            end
            ST_RELEASE: begin
                // Counter reaches HOLD_CYCLES one edge before the release, so cpu_reset
                // drops HOLD_CYCLES+1 edges after the checksum was taken.
                if (hold_q == HOLD_W_V) begin
                    state_d     = ST_RUN;
                    cpu_reset_d = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (start) begin
                    state_d     = ST_LEN;
                    done_d      = 1'b0;
                    cpu_reset_d = 1'b1;
                end
            end
            ST_ERROR: begin
                error_d = 1'b1;
                if (start) begin
                    state_d = ST_LEN;
                    error_d = 1'b0;
                end
            end
            default: state_d = ST_LEN;
        endcase

        in_ready_d = is_loading(state_d);
        busy_d     = is_loading(state_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_LEN;
            cnt_q         <= '0;
            len_q         <= '0;
            hold_q        <= '0;
            rom_address_q <= '0;
            rom_in_q      <= '0;
            rom_load_q    <= 1'b0;
            cpu_reset_q   <= 1'b1;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            hold_q        <= hold_d;
            rom_address_q <= rom_address_d;
            rom_in_q      <= rom_in_d;
            rom_load_q    <= rom_load_d;
            cpu_reset_q   <= cpu_reset_d;
            done_q        <= done_d;
            error_q       <= error_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign rom_address = rom_address_q;
    assign rom_in      = rom_in_q;
    assign rom_load    = rom_load_q;
    assign cpu_reset   = cpu_reset_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule
